// File: rtl/ibus_responder.sv
// Memory-side instruction-bus responder: accepts one fetch at a time and returns
// the addressed 32-bit word from a preloadable array after a fixed latency.
module ibus_responder #(
   parameter int unsigned DEPTH   = 4096,
   parameter int unsigned LATENCY = 2,
   parameter logic [63:0] BASE    = 64'h8000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ireq_valid,
   input  logic [63:0]              ireq_addr,
   output logic                     iresp_addr_ok,
   output logic                     iresp_data_ok,
   output logic [31:0]              iresp_data,
   output logic                     iresp_err,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_idx,
   input  logic [31:0]              load_data
);

   localparam int unsigned IW   = $clog2(DEPTH);
   localparam int unsigned CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [63:0] SPAN = 64'(DEPTH) << 2;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   logic [63:0]    addr_q;
   logic           addr_ok_q;
   logic           data_ok_q;
   logic           err_q;
   logic [31:0]    rdata;
   logic [31:0]    mem [DEPTH];

   logic           accept;
   logic           fire;
   logic [63:0]    off;
   logic           misaligned;
   logic           out_of_range;
   logic [IW-1:0]  idx;

   // Range test uses the offset rather than BASE+SPAN so a BASE near the top
   // of the address space cannot wrap.
   always_comb begin
      off          = addr_q - BASE;
      misaligned   = (addr_q[1:0] != 2'b00);
      out_of_range = (addr_q < BASE) || (off >= SPAN);
      idx          = off[IW+1:2];
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            if (ireq_valid) begin
               accept    = 1'b1;
               cnt_nxt   = CW'(LATENCY - 1);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               fire      = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         addr_ok_q <= 1'b0;
         data_ok_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         addr_ok_q <= accept;
         data_ok_q <= fire;
         if (accept) addr_q <= ireq_addr;
         if (fire)   err_q  <= misaligned | out_of_range;
      end
   end

   // Unreset array with a registered synchronous read; the read register
   // samples the old word when a preload hits the same index on that edge.
   always_ff @(posedge clk) begin
      if (load_en) mem[load_idx] <= load_data;
      if (fire)    rdata         <= mem[idx];
   end

   // The read register sits inside the RAM, so response data is qualified by
   // the registered flags to stay zero outside the data_ok cycle and on error.
   always_comb begin
      iresp_addr_ok = addr_ok_q;
      iresp_data_ok = data_ok_q;
      iresp_err     = data_ok_q & err_q;
      iresp_data    = (data_ok_q && !err_q) ? rdata : '0;
   end

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder at default parameters (LATENCY=2,
// DEPTH=4096, BASE=0x8000_0000) with hand-computed expected responses.
module tb_ibus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        iresp_err;
   logic        load_en;
   logic [11:0] load_idx;
   logic [31:0] load_data;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   ibus_responder #(
      .DEPTH   (4096),
      .LATENCY (2),
      .BASE    (64'h8000_0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .iresp_addr_ok (iresp_addr_ok),
      .iresp_data_ok (iresp_data_ok),
      .iresp_data    (iresp_data),
      .iresp_err     (iresp_err),
      .load_en       (load_en),
      .load_idx      (load_idx),
      .load_data     (load_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [11:0] i, input logic [31:0] d);
      load_en   = 1'b1;
      load_idx  = i;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   // Request raised in cycle 0; addr_ok expected in cycle 1, data_ok in cycle 3.
   task automatic do_req(input string tag, input logic [63:0] a,
                         input logic [31:0] ed, input logic ee);
      ireq_valid = 1'b1;
      ireq_addr  = a;
      tick();
      check({tag, ".c1.addr_ok"}, 64'(iresp_addr_ok), 64'd1);
      check({tag, ".c1.data_ok"}, 64'(iresp_data_ok), 64'd0);
      tick();
      check({tag, ".c2.addr_ok"}, 64'(iresp_addr_ok), 64'd0);
      check({tag, ".c2.data_ok"}, 64'(iresp_data_ok), 64'd0);
      tick();
      check({tag, ".c3.addr_ok"}, 64'(iresp_addr_ok), 64'd0);
      check({tag, ".c3.data_ok"}, 64'(iresp_data_ok), 64'd1);
      check({tag, ".c3.data"},    64'(iresp_data),    64'(ed));
      check({tag, ".c3.err"},     64'(iresp_err),     64'(ee));
      ireq_valid = 1'b0;
      tick();
      check({tag, ".c4.data_ok"}, 64'(iresp_data_ok), 64'd0);
      check({tag, ".c4.data"},    64'(iresp_data),    64'd0);
      check({tag, ".c4.err"},     64'(iresp_err),     64'd0);
   endtask

   initial begin
      reset      = 1'b0;
      ireq_valid = 1'b0;
      ireq_addr  = '0;
      load_en    = 1'b0;
      load_idx   = '0;
      load_data  = '0;
      tick();
      tick();
      check("rst.addr_ok", 64'(iresp_addr_ok), 64'd0);
      check("rst.data_ok", 64'(iresp_data_ok), 64'd0);
      check("rst.data",    64'(iresp_data),    64'd0);
      check("rst.err",     64'(iresp_err),     64'd0);
      reset = 1'b1;
      tick();

      preload(12'd0,    32'h0000_0513);
      preload(12'd1,    32'h00A0_0593);
      preload(12'd2,    32'h1234_5678);
      preload(12'd3,    32'h1111_1111);
      preload(12'd4,    32'hDEAD_BEEF);
      preload(12'd4095, 32'hCAFE_F00D);

      do_req("basic", 64'h8000_0000, 32'h0000_0513, 1'b0);

      // Held request, re-driven to the next word right after data_ok:
      // acceptances in cycles 1 and 5, responses in cycles 3 and 7.
      ireq_valid = 1'b1;
      ireq_addr  = 64'h8000_0000;
      for (int cyc = 1; cyc <= 8; cyc++) begin
         tick();
         check($sformatf("b2b.c%0d.addr_ok", cyc), 64'(iresp_addr_ok),
               64'((cyc == 1) || (cyc == 5)));
         check($sformatf("b2b.c%0d.data_ok", cyc), 64'(iresp_data_ok),
               64'((cyc == 3) || (cyc == 7)));
         if (cyc == 3) check("b2b.data0", 64'(iresp_data), 64'h0000_0513);
         if (cyc == 7) check("b2b.data1", 64'(iresp_data), 64'h00A0_0593);
         if (cyc == 3) ireq_addr  = 64'h8000_0004;
         if (cyc == 7) ireq_valid = 1'b0;
      end

      do_req("misalign", 64'h8000_0002,   32'h0, 1'b1);
      do_req("below",    64'h7FFF_FFFC,   32'h0, 1'b1);
      do_req("top",      64'h8000_4000,   32'h0, 1'b1);
      do_req("far",      64'h1_8000_0000, 32'h0, 1'b1);
      do_req("last",     64'h8000_3FFC,   32'hCAFE_F00D, 1'b0);

      // Request withdrawn and address moved after acceptance.
      ireq_valid = 1'b1;
      ireq_addr  = 64'h8000_0008;
      tick();
      check("commit.c1.addr_ok", 64'(iresp_addr_ok), 64'd1);
      ireq_valid = 1'b0;
      ireq_addr  = 64'h8000_0010;
      tick();
      check("commit.c2.data_ok", 64'(iresp_data_ok), 64'd0);
      tick();
      check("commit.c3.data_ok", 64'(iresp_data_ok), 64'd1);
      check("commit.c3.data",    64'(iresp_data),    64'h1234_5678);
      tick();

      // Asynchronous reset during BUSY.
      ireq_valid = 1'b1;
      ireq_addr  = 64'h8000_0004;
      tick();
      check("abort.addr_ok", 64'(iresp_addr_ok), 64'd1);
      #2;
      reset      = 1'b0;
      ireq_valid = 1'b0;
      #1;
      check("abort.async.addr_ok", 64'(iresp_addr_ok), 64'd0);
      check("abort.async.data_ok", 64'(iresp_data_ok), 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("abort.rst%0d.data_ok", k), 64'(iresp_data_ok), 64'd0);
      end
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("abort.post%0d.data_ok", k), 64'(iresp_data_ok), 64'd0);
      end
      do_req("after_rst", 64'h8000_0004, 32'h00A0_0593, 1'b0);

      // Preload collides with the in-flight read on the BUSY->RESP edge.
      ireq_valid = 1'b1;
      ireq_addr  = 64'h8000_000C;
      tick();
      check("rbw.c1.addr_ok", 64'(iresp_addr_ok), 64'd1);
      tick();
      load_en   = 1'b1;
      load_idx  = 12'd3;
      load_data = 32'h2222_2222;
      tick();
      load_en    = 1'b0;
      ireq_valid = 1'b0;
      check("rbw.c3.data_ok", 64'(iresp_data_ok), 64'd1);
      check("rbw.c3.data",    64'(iresp_data),    64'h1111_1111);
      tick();
      do_req("rbw.again", 64'h8000_000C, 32'h2222_2222, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
